nibbler_ctrl: RTL and testbench

- Instruction sequencer and datapath controller for the Nibbler 4-bit CPU.
- Fetches 8-bit instructions from a synchronous program ROM and decodes them.
- Drives the 4-bit ALU's operand, select and carry-in inputs, and consumes its result, Cout and eq outputs.
- Owns the accumulator, C/Z flags, PC, data-memory accesses, the output port and branching.

---
 rtl/nibbler_ctrl.sv | 142 ++++++++++++++
 tb/tb_nibbler_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/nibbler_ctrl.sv
// nibbler_ctrl: instruction sequencer and datapath controller for the Nibbler 4-bit CPU
module nibbler_ctrl #(
    parameter int N = 4,
    parameter int ADDR_W = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [4:0]        alu_s,
    output logic              alu_ncin,
    input  logic [N-1:0]      alu_result,
    input  logic              alu_cout,
    input  logic              alu_eq,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [N-1:0]      dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [N-1:0]      dmem_rdata,
    input  logic [N-1:0]      in_data,
    output logic [N-1:0]      out_data,
    output logic              out_strobe,
    output logic              halted
);
    typedef enum logic [2:0] {F1, D1, F2, D2, EX, MW, HLT} state_t;

    localparam logic [4:0] S_PASSA = 5'b00000;
    localparam logic [4:0] S_SUB   = 5'b00110;
    localparam logic [4:0] S_PASSB = 5'b11010;
    localparam logic [4:0] S_ADD   = 5'b01001;
    localparam logic [4:0] S_NOR   = 5'b10001;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d, op2_q, op2_d;
    logic [N-1:0]      acc_q, acc_d, out_q, out_d;
    logic              c_q, c_d, z_q, z_d, strobe_q, strobe_d;
    logic [3:0]        opc, imm;
    logic              taken;

    assign opc        = ir_q[7:4];
    assign imm        = ir_q[3:0];
    assign rom_addr   = pc_q;
    assign alu_a      = acc_q;
    assign alu_ncin   = alu_s != S_SUB;
    assign dmem_addr  = ADDR_W'({imm, op2_q});
    assign dmem_wdata = acc_q;
    assign out_data   = out_q;
    assign out_strobe = strobe_q;
    assign halted     = state_q == HLT;
    assign taken      = opc == 4'h8 || (opc == 4'h9 && c_q) || (opc == 4'hA && !c_q) ||
                        (opc == 4'hB && z_q) || (opc == 4'hC && !z_q);

    // architectural state register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= F1;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            op2_q    <= op2_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            z_q      <= z_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
        end
    end

    // sequencing, decode and ALU/memory control
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        op2_d    = op2_q;
        acc_d    = acc_q;
        c_d      = c_q;
        z_d      = z_q;
        out_d    = out_q;
        strobe_d = 1'b0;
        alu_s    = S_PASSA;
        alu_b    = '0;
        dmem_we  = 1'b0;
        dmem_re  = 1'b0;
        case (state_q)
            F1: state_d = D1;
            D1: begin
                ir_d    = rom_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = (rom_data[7] && rom_data[7:4] != 4'hF) ? F2 : EX;
            end
            F2: state_d = D2;
            D2: begin
                op2_d   = rom_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = EX;
            end
            EX: begin
                state_d = opc == 4'hD ? MW : opc == 4'hF ? HLT : F1;
                alu_s   = (opc == 4'h1 || opc == 4'h6) ? S_PASSB :
                          opc == 4'h2 ? S_ADD :
                          (opc == 4'h3 || opc == 4'h5) ? S_SUB :
                          opc == 4'h4 ? S_NOR : S_PASSA;
                alu_b   = opc == 4'h6 ? in_data : (opc >= 4'h1 && opc <= 4'h5) ? N'(imm) : '0;
                if (opc >= 4'h1 && opc <= 4'h6) begin
                    c_d = alu_cout;
                    z_d = alu_eq;
                    if (opc != 4'h5) acc_d = alu_result;
                end
                if (opc == 4'h7) begin
                    out_d    = acc_q;
                    strobe_d = 1'b1;
                end
                if (taken) pc_d = ADDR_W'({imm, op2_q});
                dmem_re = opc == 4'hD;
                dmem_we = opc == 4'hE;
            end
            MW: begin
                alu_s   = S_PASSB;
                alu_b   = dmem_rdata;
                acc_d   = alu_result;
                c_d     = alu_cout;
                z_d     = alu_eq;
                state_d = F1;
            end
            HLT: state_d = HLT;
            default: state_d = F1;
        endcase
    end
endmodule

// File: tb/tb_nibbler_ctrl.sv
// tb_nibbler_ctrl: scoreboard bench with ROM, data memory and 4-bit ALU models
module tb_nibbler_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] rom_addr, dmem_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [3:0]  alu_a, alu_b, alu_result, dmem_wdata, out_data;
    logic [3:0]  dmem_rdata = 4'h0;
    logic [3:0]  in_data = 4'hA;
    logic [4:0]  alu_s, sum;
    logic        alu_ncin, alu_cout, alu_eq, dmem_we, dmem_re, out_strobe, halted;
    logic [7:0]  rom [0:4095];
    logic [3:0]  mem [0:4095];
    logic        hprev = 1'b0;
    int          checks = 0;
    int          passes = 0;

    typedef struct {int kind; logic [11:0] addr; logic [3:0] data;} ev_t;
    ev_t q[$];

    nibbler_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_ncin(alu_ncin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_eq(alu_eq),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_re(dmem_re), .dmem_rdata(dmem_rdata), .in_data(in_data),
        .out_data(out_data), .out_strobe(out_strobe), .halted(halted)
    );

    always #5 clk = ~clk;

    // ALU: cout on SUB is the no-borrow carry of a + ~b + cin
    always_comb begin
        sum = {1'b0, alu_a};
        if (alu_s == 5'b01001) sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, ~alu_ncin};
        else if (alu_s == 5'b00110) sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, ~alu_ncin};
        else if (alu_s == 5'b11010) sum = {1'b0, alu_b};
        else if (alu_s == 5'b10001) sum = {1'b0, ~(alu_a | alu_b)};
    end
    assign alu_result = sum[3:0];
    assign alu_cout   = sum[4];
    assign alu_eq     = sum[3:0] == 4'h0;

    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
        if (dmem_we) mem[dmem_addr] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= mem[dmem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push(input int k, input logic [11:0] a, input logic [3:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic pop(input int k, input logic [11:0] a, input logic [3:0] d);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none", k, a, d);
        end else begin
            e = q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_addr", a, e.addr);
            chk("ev_data", d, e.data);
        end
    endtask

    // monitor: kinds 0=OUT 1=ST 2=LD 3=HALT
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_s == 5'b00110) chk("ncin_sub", alu_ncin, 0);
            if (alu_s == 5'b01001) chk("ncin_add", alu_ncin, 1);
            if (out_strobe) pop(0, 12'h000, out_data);
            if (dmem_we) pop(1, dmem_addr, dmem_wdata);
            if (dmem_re) pop(2, dmem_addr, 4'h0);
            if (halted && !hprev) pop(3, 12'h000, 4'h0);
            hprev = halted;
        end else hprev = 1'b0;
    end

    task automatic wait_halt(input string nm);
        for (int i = 0; i < 3000 && !halted; i++) @(posedge clk);
        #1 chk(nm, halted, 1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin rom[i] = 8'h00; mem[i] = 4'h0; end
        rom[12'h000] = 8'h15; rom[12'h001] = 8'h23; rom[12'h002] = 8'h70;
        rom[12'h003] = 8'h1F; rom[12'h004] = 8'h21; rom[12'h005] = 8'h70;
        rom[12'h006] = 8'h90; rom[12'h007] = 8'h40;
        rom[12'h040] = 8'h13; rom[12'h041] = 8'h53; rom[12'h042] = 8'hC0; rom[12'h043] = 8'h50;
        rom[12'h044] = 8'h70; rom[12'h045] = 8'hA0; rom[12'h046] = 8'h60;
        rom[12'h047] = 8'h19; rom[12'h048] = 8'hE1; rom[12'h049] = 8'h23;
        rom[12'h04A] = 8'h10; rom[12'h04B] = 8'hD1; rom[12'h04C] = 8'h23;
        rom[12'h04D] = 8'h70; rom[12'h04E] = 8'hB0; rom[12'h04F] = 8'h55;
        rom[12'h050] = 8'h40; rom[12'h051] = 8'h70; rom[12'h052] = 8'h60;
        rom[12'h053] = 8'h3B; rom[12'h054] = 8'h70; rom[12'h055] = 8'h8F; rom[12'h056] = 8'hFF;
        rom[12'hFFF] = 8'h80;
        rom[12'h015] = 8'h70; rom[12'h016] = 8'hA0; rom[12'h017] = 8'h70;
        rom[12'h070] = 8'hF0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", rom_addr, 12'h000);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_strobe", out_strobe, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_re", dmem_re, 0);
        chk("rst_halted", halted, 0);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_alu_a", alu_a, 0);
        push(0, 0, 4'h8); push(0, 0, 4'h0); push(0, 0, 4'h3);
        push(1, 12'h123, 4'h9); push(2, 12'h123, 0); push(0, 0, 4'h9);
        push(0, 0, 4'h6); push(0, 0, 4'hF); push(0, 0, 4'hF); push(3, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("addi_alu_s", alu_s, 5'b01001);
        chk("addi_alu_b", alu_b, 4'h3);
        chk("addi_alu_a", alu_a, 4'h5);
        wait_halt("halt1_timeout");
        repeat (8) @(posedge clk);
        #1;
        chk("hlt_rom_addr", rom_addr, 12'h071);
        chk("hlt_alu_s", alu_s, 0);
        chk("hlt_halted", halted, 1);
        chk("sb_drain1", q.size(), 0);

        @(negedge clk) rst_n = 1'b0;
        rom[0] = 8'h17; rom[1] = 8'hD1; rom[2] = 8'h23; rom[3] = 8'h70; rom[4] = 8'hF0;
        push(2, 12'h123, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 100 && !dmem_re; i++) @(negedge clk);
        chk("ld_re_seen", dmem_re, 1);
        @(posedge clk);
        #1;
        chk("mw_alu_s", alu_s, 5'b11010);
        chk("mw_alu_b", alu_b, 4'h9);
        chk("mw_alu_a", alu_a, 4'h7);
        rst_n = 1'b0;
        #1;
        chk("arst_dmem_re", dmem_re, 0);
        chk("arst_rom_addr", rom_addr, 12'h000);
        chk("arst_alu_s", alu_s, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_dmem_addr", dmem_addr, 12'h000);
        chk("arst_halted", halted, 0);
        chk("arst_out_data", out_data, 0);
        chk("sb_drain2", q.size(), 0);
        push(2, 12'h123, 0); push(0, 0, 4'h9); push(3, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        wait_halt("halt2_timeout");
        repeat (2) @(posedge clk);
        #1;
        chk("hlt2_rom_addr", rom_addr, 12'h005);
        chk("sb_drain3", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
